// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between the FU completion ports and the CDB arbiter.
// master = FU/pipeline side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_FU    = 5,
  parameter int ROB_TAG_W = 5,
  parameter int SEL_W     = 3
);
  logic [NUM_FU-1:0]           fu_valid;
  logic [NUM_FU*ROB_TAG_W-1:0] fu_rob_tag;
  logic                        cdb_stall;
  logic                        squash;
  logic [NUM_FU-1:0]           fu_grant;
  logic                        select_flag;
  logic [SEL_W-1:0]            select;
  logic [ROB_TAG_W-1:0]        ROB_tag;

  modport master (
    output fu_valid, fu_rob_tag, cdb_stall, squash,
    input  fu_grant, select_flag, select, ROB_tag
  );

  modport slave (
    input  fu_valid, fu_rob_tag, cdb_stall, squash,
    output fu_grant, select_flag, select, ROB_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one-hot combinational FU ack, registered CDB controls.
// Optional CDB_ARB_STATS_EN adds saturating grant and stall counters.
module cdb_arbiter #(
  parameter int NUM_FU    = 5,
  parameter int ROB_TAG_W = 5,
  parameter int SEL_W     = 3
) (
  input  logic clock,
  input  logic reset,
  cdb_arbiter_if.slave bus
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_FU*16-1:0] stat_grants,
  output logic [15:0]          stat_stall_cycles
`endif
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     next_ptr;
  logic [PTR_W:0]       idx;
  logic                 hit;
  logic                 go;
  logic [NUM_FU-1:0]    grant;
  logic [ROB_TAG_W-1:0] win_tag;
  logic                 flag_q;
  logic [SEL_W-1:0]     sel_q;
  logic [ROB_TAG_W-1:0] tag_q;

  // Scan from rr_ptr, wrapping; the first valid FU wins.
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_FU))
        idx = idx - (PTR_W+1)'(NUM_FU);
      if (!hit && bus.fu_valid[idx[PTR_W-1:0]]) begin
        hit = 1'b1;
        win = idx[PTR_W-1:0];
      end
    end
  end

  assign go = hit & ~(reset | bus.squash | bus.cdb_stall);

  always_comb begin
    grant = '0;
    if (go)
      grant[win] = 1'b1;
  end

  assign win_tag  = bus.fu_rob_tag[int'(win)*ROB_TAG_W +: ROB_TAG_W];
  assign next_ptr = (win == PTR_W'(NUM_FU-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      flag_q <= 1'b0;
      sel_q  <= '0;
      tag_q  <= '0;
      rr_ptr <= '0;
    end else begin
      flag_q <= go;
      if (bus.squash) begin
        rr_ptr <= '0;
      end else if (go) begin
        sel_q  <= SEL_W'(win);
        tag_q  <= win_tag;
        rr_ptr <= next_ptr;
      end
    end
  end

  assign bus.fu_grant    = grant;
  assign bus.select_flag = flag_q;
  assign bus.select      = sel_q;
  assign bus.ROB_tag     = tag_q;

`ifdef CDB_ARB_STATS_EN
  logic [15:0] grants_q [NUM_FU];
  logic [15:0] stall_q;

  // Counters survive squash; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++)
        grants_q[i] <= '0;
      stall_q <= '0;
    end else begin
      if (go && grants_q[win] != 16'hFFFF)
        grants_q[win] <= grants_q[win] + 16'd1;
      if (bus.cdb_stall && (|bus.fu_valid)
          && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_FU; i++)
      stat_grants[i*16 +: 16] = grants_q[i];
  end

  assign stat_stall_cycles = stall_q;
`endif
endmodule
